instr_fetch_queue: RTL and testbench

Instruction fetch unit with a small prefetch queue. It sits directly upstream of the decode stage. It issues word-addressed requests to instruction memory, buffers in-order responses tagged with their next-PC, and presents them to decode over a valid/ready handshake. A taken-branch redirect from execute flushes the queue, and the block discards any responses already in flight.

---
 rtl/ifq_pkg.sv | 27 ++
 rtl/ifq_fifo.sv | 70 +++++++
 rtl/instr_fetch_queue.sv | 157 +++++++++++++++
 tb/tb_instr_fetch_queue.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// rtl/ifq_pkg.sv - shared types, defaults and helpers for the instruction fetch queue
//
// Purpose: fetch FSM state encoding, default geometry and reset PC, and the
// queue entry layout {ir, npc} shared by instr_fetch_queue and its FIFOs.
package ifq_pkg;

  localparam int          IFQ_DEPTH    = 4;
  localparam int          IFQ_MAX_OUT  = 2;
  localparam logic [31:0] IFQ_RESET_PC = 32'd0;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ifq_state_e;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } ifq_entry_t;

  // PC is a word index; the increment wraps 32'hFFFF_FFFF to 0.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd1;
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// rtl/ifq_fifo.sv - synchronous FIFO with flush, any depth >= 1
//
// Purpose: in-order storage used for both the instruction queue and the
// outstanding-request PC tag queue.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   flush           empties the FIFO on the edge (wins over push/pop)
//   push, push_data write one entry
//   pop             drop the head entry
//   head_data       entry at the head (meaningful when count != 0)
//   count           number of stored entries, 0..DEPTH
module ifq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW       = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only taken when the head leaves on the same edge.
  assign do_pop    = pop && (cnt != '0) && !flush;
  assign do_push   = push && ((cnt != FULL_CNT) || do_pop) && !flush;
  assign head_data = mem[rd_ptr];
  assign count     = cnt;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      end
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - instruction fetch unit with prefetch queue and branch redirect
//
// Purpose: issues word-addressed imem requests, buffers in-order responses
// tagged with next-PC, and hands them to decode over valid/ready. A taken
// branch flushes the queue and the responses still in flight are discarded.
// Optional feature macro: IFQ_STATS_EN adds stat_flush/stat_stall/stat_drop.
// Ports:
//   clk, RN                     clock, asynchronous active-high reset
//   imem_req/imem_addr/imem_ready      request channel (word address)
//   imem_rvalid/imem_rdata             in-order response channel
//   br_en/br_target                    redirect from execute
//   if_valid/if_ready/if_ir/if_npc     queue head to decode
//   stat_flush/stat_stall/stat_drop    wrapping event counters (IFQ_STATS_EN)
module instr_fetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH    = IFQ_DEPTH,
  parameter int          MAX_OUT  = IFQ_MAX_OUT,
  parameter logic [31:0] RESET_PC = IFQ_RESET_PC
) (
  input  logic        clk,
  input  logic        RN,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        br_en,
  input  logic [31:0] br_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_ir,
  output logic [31:0] if_npc
`ifdef IFQ_STATS_EN
  ,
  output logic [31:0] stat_flush,
  output logic [31:0] stat_stall,
  output logic [7:0]  stat_drop
`endif
);

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int CW = $clog2(DEPTH + 1);

  ifq_state_e    state;
  logic [31:0]   pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] discard;
  logic [CW-1:0] q_count;
  logic [31:0]   tag_pc;
  ifq_entry_t    q_head;
  ifq_entry_t    q_wdata;

  logic          room;
  logic          accept;
  logic          dropping;
  logic          enq;
  logic          deq;
  logic [OW-1:0] out_after_rsp;
  logic [OW-1:0] discard_nxt;

  // Issue budget counts buffered entries plus in-flight requests, so every
  // accepted request already owns a queue slot when its response returns.
  assign room = ((int'(q_count) + int'(outstanding)) < DEPTH) && (int'(outstanding) < MAX_OUT);

  assign imem_req  = (state == RUN) && room && !br_en;
  assign imem_addr = pc;

  assign accept        = imem_req && imem_ready;
  assign dropping      = imem_rvalid && (discard != '0);
  assign enq           = imem_rvalid && (discard == '0) && !br_en;
  assign deq           = if_valid && if_ready && !br_en;
  assign out_after_rsp = outstanding - OW'(imem_rvalid);
  assign discard_nxt   = discard - OW'(dropping);

  assign q_wdata = '{ir: imem_rdata, npc: pc_inc(tag_pc)};

  assign if_valid = (q_count != '0);
  assign if_ir    = if_valid ? q_head.ir  : 32'd0;
  assign if_npc   = if_valid ? q_head.npc : 32'd0;

  always_ff @(posedge clk or posedge RN) begin
    if (RN) begin
      state   <= BOOT;
      pc      <= RESET_PC;
      discard <= '0;
    end else if (br_en) begin
      // Everything still in flight after this edge belongs to the old path.
      pc      <= br_target;
      discard <= out_after_rsp;
      state   <= (out_after_rsp != '0) ? DRAIN : RUN;
    end else begin
      if (accept) begin
        pc <= pc_inc(pc);
      end
      discard <= discard_nxt;
      case (state)
        BOOT:    state <= RUN;
        RUN:     state <= RUN;
        DRAIN:   if (discard_nxt == '0) state <= RUN;
        default: state <= BOOT;
      endcase
    end
  end

  ifq_fifo #(
    .WIDTH ($bits(ifq_entry_t)),
    .DEPTH (DEPTH)
  ) u_inst_q (
    .clk       (clk),
    .rst       (RN),
    .flush     (br_en),
    .push      (enq),
    .push_data (q_wdata),
    .pop       (deq),
    .head_data (q_head),
    .count     (q_count)
  );

  // One tag per in-flight request; its occupancy is the outstanding count.
  // Tags are retired by every response, including discarded ones, so the
  // FIFO never needs flushing on a redirect.
  ifq_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUT)
  ) u_tag_q (
    .clk       (clk),
    .rst       (RN),
    .flush     (1'b0),
    .push      (accept),
    .push_data (pc),
    .pop       (imem_rvalid),
    .head_data (tag_pc),
    .count     (outstanding)
  );

`ifdef IFQ_STATS_EN
  always_ff @(posedge clk or posedge RN) begin
    if (RN) begin
      stat_flush <= 32'd0;
      stat_stall <= 32'd0;
      stat_drop  <= 8'd0;
    end else begin
      if (br_en) begin
        stat_flush <= stat_flush + 32'd1;
      end
      if (if_ready && !if_valid) begin
        stat_stall <= stat_stall + 32'd1;
      end
      if (dropping || (imem_rvalid && br_en)) begin
        stat_drop <= stat_drop + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - randomized, model-checked bench for instr_fetch_queue
module tb_instr_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'd0;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } ent_t;

  logic        clk = 1'b0;
  logic        RN  = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready  = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = 32'd0;
  logic        br_en       = 1'b0;
  logic [31:0] br_target   = 32'd0;
  logic        if_valid;
  logic        if_ready    = 1'b0;
  logic [31:0] if_ir;
  logic [31:0] if_npc;
`ifdef IFQ_STATS_EN
  logic [31:0] stat_flush;
  logic [31:0] stat_stall;
  logic [7:0]  stat_drop;
`endif

  always #5 clk = ~clk;

  instr_fetch_queue #(
    .DEPTH    (DEPTH),
    .MAX_OUT  (MAX_OUT),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .RN          (RN),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .br_en       (br_en),
    .br_target   (br_target),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_ir       (if_ir),
    .if_npc      (if_npc)
`ifdef IFQ_STATS_EN
    ,
    .stat_flush  (stat_flush),
    .stat_stall  (stat_stall),
    .stat_drop   (stat_drop)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // stimulus knobs
  int lat_min, lat_max, p_ready, p_ifr, p_br, br_mode;
  bit br_hit;

  // behavioural model: what decode must see, what memory still owes
  ent_t        mq[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] m_pc;
  int          m_disc;
  bit          m_boot;
  logic [31:0] m_flush, m_stall;
  logic [7:0]  m_drop;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ({a[15:0], ~a[15:0]} ^ 32'h1234_5678) + {a[31:16], 16'h0000};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // A request may go out only outside boot and drain, with a slot reserved for
  // its response, under the in-flight cap, and not while a redirect is strobed.
  function automatic bit exp_req();
    return !RN && !m_boot && (m_disc == 0) && (mq.size() + pend_addr.size() < DEPTH)
           && (pend_addr.size() < MAX_OUT) && !br_en;
  endfunction

  task automatic m_clear();
    mq.delete();
    pend_addr.delete();
    pend_due.delete();
    m_pc    = RESET_PC;
    m_disc  = 0;
    m_boot  = 1'b1;
    m_flush = 32'd0;
    m_stall = 32'd0;
    m_drop  = 8'd0;
  endtask

  task automatic model_edge();
    bit acc, deq;
    logic [31:0] a;
    int due;
    cyc++;
    if (RN) begin
      m_clear();
      return;
    end
    acc = exp_req() && imem_ready;
    deq = (mq.size() > 0) && if_ready && !br_en;
    if (if_ready && mq.size() == 0) m_stall = m_stall + 32'd1;
    if (deq) void'(mq.pop_front());
    if (imem_rvalid) begin
      a = pend_addr.pop_front();
      void'(pend_due.pop_front());
      if (m_disc > 0) begin
        m_disc--;
        m_drop = m_drop + 8'd1;
      end else if (br_en) begin
        m_drop = m_drop + 8'd1;
      end else begin
        mq.push_back('{ir: mem_word(a), npc: a + 32'd1});
      end
    end
    if (br_en) begin
      mq.delete();
      m_disc  = pend_addr.size();
      m_pc    = br_target;
      m_flush = m_flush + 32'd1;
    end else if (acc) begin
      due = cyc + $urandom_range(lat_min, lat_max);
      if (pend_due.size() > 0 && due < pend_due[$]) due = pend_due[$];
      pend_addr.push_back(m_pc);
      pend_due.push_back(due);
      m_pc = m_pc + 32'd1;
    end
    m_boot = 1'b0;
  endtask

  task automatic drive();
    bit rv;
    rv          = (pend_addr.size() > 0) && (pend_due[0] <= cyc);
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(pend_addr[0]) : $urandom;
    imem_ready  = ($urandom_range(0, 99) < p_ready);
    if_ready    = ($urandom_range(0, 99) < p_ifr);
    br_en       = 1'b0;
    br_target   = $urandom;
    if (br_mode == 1 && pend_addr.size() == 2 && !rv) begin
      br_en = 1'b1; br_target = 32'd25; br_mode = 0; br_hit = 1'b1;
    end else if (br_mode == 2 && mq.size() > 0 && pend_addr.size() == 1 && rv && if_ready) begin
      br_en = 1'b1; br_target = 32'hFFFF_FFFE; br_mode = 0; br_hit = 1'b1;
    end else if ($urandom_range(0, 999) < p_br) begin
      br_en = 1'b1;
      br_target = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 5)) : $urandom;
    end
  endtask

  task automatic compare();
    chk("imem_req", 32'(imem_req), 32'(exp_req()));
    chk("imem_addr", imem_addr, m_pc);
    chk("if_valid", 32'(if_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("if_ir", if_ir, mq[0].ir);
      chk("if_npc", if_npc, mq[0].npc);
    end
`ifdef IFQ_STATS_EN
    chk("stat_flush", stat_flush, m_flush);
    chk("stat_stall", stat_stall, m_stall);
    chk("stat_drop", 32'(stat_drop), 32'(m_drop));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    drive();
    #1;
    compare();
  endtask

  // Asserted mid-cycle so the clear is seen before any clock edge.
  task automatic do_reset();
    RN = 1'b1;
    br_en = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; if_ready = 1'b0;
    m_clear();
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_ir", if_ir, 32'd0);
    chk("rst_if_npc", if_npc, 32'd0);
`ifdef IFQ_STATS_EN
    chk("rst_stat_flush", stat_flush, 32'd0);
    chk("rst_stat_drop", 32'(stat_drop), 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    RN = 1'b0;
    drive();
    #1;
    compare();
  endtask

  initial begin
    bit found;
    #1;

    // steady fetch out of reset: 1-cycle memory, decode always ready
    lat_min = 0; lat_max = 0; p_ready = 100; p_ifr = 100; p_br = 0; br_mode = 0;
    do_reset();
    step(); chk("boot_e1_valid", 32'(if_valid), 32'd0);
    step(); chk("boot_e2_valid", 32'(if_valid), 32'd0);
    chk("boot_e2_addr", imem_addr, 32'd1);
    step(); chk("first_valid", 32'(if_valid), 32'd1);
    chk("first_npc", if_npc, 32'd1);
    chk("first_ir", if_ir, 32'h1234_A987);
    step(); chk("second_npc", if_npc, 32'd2);

    // backpressure fills the queue and stops issue
    p_ifr = 0;
    repeat (10) step();
    chk("bp_valid", 32'(if_valid), 32'd1);
    chk("bp_req", 32'(imem_req), 32'd0);
    chk("bp_model_depth", mq.size(), DEPTH);
    chk("bp_model_inflight", pend_addr.size(), 32'd0);
    p_ifr = 100;
    repeat (8) step();

    // redirect to 25 with two requests in flight
    lat_min = 2; lat_max = 2; br_mode = 1; br_hit = 1'b0;
    for (int i = 0; i < 60 && !br_hit; i++) step();
    chk("redir25_armed", 32'(br_hit), 32'd1);
    if (br_hit) begin
      step();
      chk("redir25_req", 32'(imem_req), 32'd0);
      chk("redir25_addr", imem_addr, 32'd25);
      chk("redir25_valid", 32'(if_valid), 32'd0);
      chk("redir25_discard", m_disc, 32'd2);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        step();
        if (if_valid) found = 1'b1;
      end
      chk("redir25_delivered", 32'(found), 32'd1);
      chk("redir25_npc", if_npc, 32'd26);
      chk("redir25_ir", if_ir, 32'h122D_A99E);
    end

    // redirect, response and dequeue on one edge, into the PC wrap
    lat_min = 0; lat_max = 0; br_mode = 2; br_hit = 1'b0;
    for (int i = 0; i < 60 && !br_hit; i++) step();
    chk("wrap_armed", 32'(br_hit), 32'd1);
    if (br_hit) begin
      step();
      chk("wrap_s0_valid", 32'(if_valid), 32'd0);
      chk("wrap_s0_req", 32'(imem_req), 32'd1);
      chk("wrap_s0_addr", imem_addr, 32'hFFFF_FFFE);
      step();
      chk("wrap_s1_valid", 32'(if_valid), 32'd0);
      chk("wrap_s1_addr", imem_addr, 32'hFFFF_FFFF);
      step();
      chk("wrap_s2_valid", 32'(if_valid), 32'd1);
      chk("wrap_s2_npc", if_npc, 32'hFFFF_FFFF);
      chk("wrap_s2_addr", imem_addr, 32'd0);
      step();
      chk("wrap_s3_npc", if_npc, 32'd0);
      step();
      chk("wrap_s4_npc", if_npc, 32'd1);
      chk("wrap_s4_ir", if_ir, 32'h1234_A987);
    end

    // randomized traffic, each phase entered through a mid-run reset
    for (int ph = 0; ph < 4; ph++) begin
      lat_min = 0;
      lat_max = $urandom_range(0, 3);
      p_ready = $urandom_range(40, 100);
      p_ifr   = $urandom_range(30, 100);
      p_br    = 40;
      repeat (20) step();
      do_reset();
      repeat (450) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
